// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
//   muldiv_op_t    : operation code presented by the execute stage
//   muldiv_state_t : sequencer states
//   MD_MUL_STEP    : default multiplier bits consumed per shift-add cycle
//   MD_MUL_CYCLES  : default shift-add cycle count
//   MD_DIV_CYCLES  : restoring-division iteration count
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   // ST_ prefix keeps state names apart from the op codes (MD_DIV is an op).
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_t;

   localparam int MD_MUL_STEP   = 8;
   localparam int MD_MUL_CYCLES = 32 / MD_MUL_STEP;
   localparam int MD_DIV_CYCLES = 32;

   // Two's-complement negate when neg is set; 0x8000_0000 maps to itself,
   // which is exactly the unsigned magnitude we want.
   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_radix2_core.sv
// One restoring-division step, purely combinational.
//   rq_in   : {remainder, quotient/dividend} before the step
//   divisor : unsigned divisor magnitude
//   rq_out  : {remainder, quotient} after shifting in one quotient bit
module div_radix2_core (
   input  logic [63:0] rq_in,
   input  logic [31:0] divisor,
   output logic [63:0] rq_out
);

   // The shifted partial remainder needs 33 bits since rem < divisor < 2^32.
   logic [33:0] diff;

   always_comb begin
      diff = {1'b0, rq_in[63:31]} - {2'b00, divisor};
      // A non-negative difference is always below the divisor, so bit 32 is
      // clear whenever the trial subtraction succeeds.
      if (diff[33:32] == 2'b00) begin
         rq_out = {diff[31:0], rq_in[30:0], 1'b1};
      end else begin
         rq_out = {rq_in[62:31], rq_in[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO result path.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   req_valid/op/a/b     : request from execute; taken on req_valid && req_ready
//   req_ready            : high only in idle
//   flush                : aborts any operation in flight
//   stall                : high while an accepted op is working
//   done                 : one-cycle strobe, hi/lo valid
//   hi, lo               : product[63:32]/[31:0] or remainder/quotient
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle 32x32 multiply
// instead of the iterative shift-add path.
//
// state   | meaning
// IDLE    | ready for a request
// MUL     | multiply on magnitudes (shift-add, or single cycle when fast)
// DIV     | one restoring step per cycle
// FIX     | apply operand signs; also reached directly on divide by zero
// DONE    | done strobe, hi/lo hold the new result
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_STEP = MD_MUL_STEP,
   parameter int DIV_ITER = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  muldiv_op_t  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MUL_CYCLES = 32 / MUL_STEP;

   muldiv_state_t state, state_nxt;

   logic        accept, op_mul, op_signed, neg_a, neg_b;
   logic        is_mul, sa, sb, div0;
   logic [31:0] mag_a, mag_b;
   logic [63:0] acc, mul_nxt, div_nxt, fix_res;
   logic [5:0]  cnt;
   logic        cnt_tc;

   assign op_mul    = (req_op == MD_MULT) || (req_op == MD_MULTU);
   assign op_signed = (req_op == MD_MULT) || (req_op == MD_DIV);
   assign neg_a     = op_signed && req_a[31];
   assign neg_b     = op_signed && req_b[31];
   assign accept    = req_valid && req_ready && !flush;
   assign cnt_tc    = (cnt == 6'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (op_mul)              state_nxt = ST_MUL;
               else if (req_b == 32'd0) state_nxt = ST_FIX;
               else                     state_nxt = ST_DIV;
            end
         end
         ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            state_nxt = flush ? ST_IDLE : ST_FIX;
`else
            if (flush)       state_nxt = ST_IDLE;
            else if (cnt_tc) state_nxt = ST_FIX;
`endif
         end
         ST_DIV: begin
            if (flush)       state_nxt = ST_IDLE;
            else if (cnt_tc) state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      stall     = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
      done      = (state == ST_DONE);
   end

`ifdef MULDIV_FAST_MUL_EN
   assign mul_nxt = {32'd0, mag_a} * {32'd0, mag_b};
`else
   // MSB-first shift-add: the top MUL_STEP bits of mag_b are consumed each
   // cycle and mag_b shifts left, so the accumulator only ever shifts left.
   logic [63:0] pp;
   always_comb begin
      pp = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (mag_b[31-i]) pp = pp + ({32'd0, mag_a} << (MUL_STEP - 1 - i));
      end
      mul_nxt = (acc << MUL_STEP) + pp;
   end
`endif

   div_radix2_core u_div_core (
      .rq_in   (acc),
      .divisor (mag_b),
      .rq_out  (div_nxt)
   );

   always_comb begin
      if (is_mul)    fix_res = (sa ^ sb) ? (~acc + 64'd1) : acc;
      else if (div0) fix_res = {neg_if(sa, mag_a), 32'hFFFF_FFFF};
      else           fix_res = {neg_if(sa, acc[63:32]), neg_if(sa ^ sb, acc[31:0])};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         is_mul <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         div0   <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  is_mul <= op_mul;
                  sa     <= neg_a;
                  sb     <= neg_b;
                  div0   <= !op_mul && (req_b == 32'd0);
                  mag_a  <= neg_if(neg_a, req_a);
                  mag_b  <= neg_if(neg_b, req_b);
                  acc    <= op_mul ? 64'd0 : {32'd0, neg_if(neg_a, req_a)};
                  cnt    <= op_mul ? 6'(MUL_CYCLES - 1) : 6'(DIV_ITER - 1);
               end
            end
            ST_MUL: begin
               acc <= mul_nxt;
`ifndef MULDIV_FAST_MUL_EN
               mag_b <= mag_b << MUL_STEP;
               cnt   <= cnt - 6'd1;
`endif
            end
            ST_DIV: begin
               acc <= div_nxt;
               cnt <= cnt - 6'd1;
            end
            ST_FIX: begin
               if (!flush) {hi, lo} <= fix_res;
            end
            default: ;
         endcase
      end
   end

endmodule
